// File: rtl/sqrt_rr_sched.sv
// rtl/sqrt_rr_sched.sv - round-robin scheduler sharing one iterative square-root core
module sqrt_rr_sched #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_rad,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [WIDTH-1:0]         rsp_root,
    output logic [WIDTH-1:0]         rsp_rem,
    output logic                     rsp_err,
    output logic                     core_start,
    output logic [WIDTH-1:0]         core_rad,
    input  logic                     core_busy,
    input  logic                     core_valid,
    input  logic [WIDTH-1:0]         core_root,
    input  logic [WIDTH-1:0]         core_rem
);

    localparam int IDW = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] core_rad_q, core_rad_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_root_q, rsp_root_d;
    logic [WIDTH-1:0] rsp_rem_q, rsp_rem_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             core_start_q, core_start_d;
    logic [WDW-1:0]   wd_q, wd_d;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand;

    // Search starts one past the last winner so every requester gets a turn within NREQ grants.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        core_rad_d = core_rad_q;
        rsp_id_d   = rsp_id_q;
        rsp_root_d = rsp_root_q;
        rsp_rem_d  = rsp_rem_q;
        rsp_err_d  = rsp_err_q;
        wd_d       = wd_q;
        case (state_q)
            S_IDLE: begin
                // core_valid is deliberately not looked at here: it may be a stale result.
                if (grant_found) begin
                    state_d    = S_ISSUE;
                    ptr_d      = grant_idx;
                    rsp_id_d   = grant_idx;
                    core_rad_d = req_rad[int'(grant_idx)*WIDTH +: WIDTH];
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_valid && !core_busy) begin
                    rsp_root_d = core_root;
                    rsp_rem_d  = core_rem;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (wd_q == WD_MAX) begin
                    rsp_root_d = '0;
                    rsp_rem_d  = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        core_start_d = (state_d == S_ISSUE);
        rsp_valid_d  = (state_d == S_RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= IDW'(NREQ - 1);
            core_rad_q   <= '0;
            rsp_id_q     <= '0;
            rsp_root_q   <= '0;
            rsp_rem_q    <= '0;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            core_start_q <= 1'b0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            core_rad_q   <= core_rad_d;
            rsp_id_q     <= rsp_id_d;
            rsp_root_q   <= rsp_root_d;
            rsp_rem_q    <= rsp_rem_d;
            rsp_err_q    <= rsp_err_d;
            rsp_valid_q  <= rsp_valid_d;
            core_start_q <= core_start_d;
            wd_q         <= wd_d;
        end
    end

    assign core_start = core_start_q;
    assign core_rad   = core_rad_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_root   = rsp_root_q;
    assign rsp_rem    = rsp_rem_q;
    assign rsp_err    = rsp_err_q;

endmodule
